// File: rtl/load_store_ctrl.sv
// load_store_ctrl
//   Sequences data-memory loads and stores (LB/LBU/LH/LHU/LW/SB/SH/SW) between
//   the MEM stage and a word-addressed, single-port, synchronous-read RAM that
//   has no byte enables. Sub-word stores are done as read-modify-write. Loads
//   pick the addressed lane and sign- or zero-extend it.
//
// Ports
//   i_clk, i_rst      clock; synchronous active-high reset
//   i_req             access request, only looked at in IDLE
//   i_we              1 = store, 0 = load
//   i_size            00 byte, 01 half, 10 word, 11 illegal
//   i_unsigned        zero-extend sub-word loads
//   i_addr            byte address
//   i_wdata           right-aligned store data
//   i_ram_rdata       RAM read data, valid one cycle after o_ram_addr
//   o_busy            high while an access is in flight
//   o_done            one-cycle completion pulse
//   o_rdata           registered, extended load result
//   o_misaligned      error pulse, coincident with o_done
//   o_ram_addr        latched word address
//   o_ram_we          RAM write strobe
//   o_ram_wdata       RAM write data (zero when not writing)
//
// State table
//   state    | meaning
//   ST_IDLE  | waiting for i_req; latches the request
//   ST_ISSUE | word address on RAM; SW writes here, others start a read
//   ST_READ  | RAM data valid: extend for loads, merge lane for SB/SH
//   ST_WRITE | write merged word back (SB/SH)
//   ST_ERR   | misaligned/illegal request reported, no RAM access
//   ST_DONE  | completion pulse

module load_store_ctrl #(
    parameter int RAM_AW = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req,
    input  logic              i_we,
    input  logic [1:0]        i_size,
    input  logic              i_unsigned,
    input  logic [31:0]       i_addr,
    input  logic [31:0]       i_wdata,
    input  logic [31:0]       i_ram_rdata,
    output logic              o_busy,
    output logic              o_done,
    output logic [31:0]       o_rdata,
    output logic              o_misaligned,
    output logic [RAM_AW-1:0] o_ram_addr,
    output logic              o_ram_we,
    output logic [31:0]       o_ram_wdata
);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_READ  = 3'd2,
        ST_WRITE = 3'd3,
        ST_ERR   = 3'd4,
        ST_DONE  = 3'd5
    } state_t;

    state_t state, state_nxt;

    logic [RAM_AW-1:0] addr_q;
    logic [1:0]        off_q;
    logic [1:0]        size_q;
    logic              unsigned_q;
    logic              we_q;
    logic [31:0]       wdata_q;
    logic [31:0]       merge_q;
    logic [31:0]       rdata_q;

    logic              misaligned_req;
    logic [31:0]       load_val;
    logic [31:0]       merge_val;
    logic [7:0]        byte_sel;
    logic [15:0]       half_sel;
    logic              ram_we_raw;

    // Upper address bits beyond the RAM are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^i_addr[31:RAM_AW+2];

    assign misaligned_req = (i_size == 2'b11)
                         || (i_size == SZ_HALF && i_addr[0])
                         || (i_size == SZ_WORD && i_addr[1:0] != 2'b00);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (i_req) begin
                    state_nxt = misaligned_req ? ST_ERR : ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                state_nxt = (we_q && size_q == SZ_WORD) ? ST_DONE : ST_READ;
            end
            ST_READ: begin
                state_nxt = we_q ? ST_WRITE : ST_DONE;
            end
            ST_WRITE: state_nxt = ST_DONE;
            ST_ERR:   state_nxt = ST_IDLE;
            ST_DONE:  state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    // Lane selection for loads.
    always_comb begin
        byte_sel = 8'h00;
        case (off_q)
            2'b00:   byte_sel = i_ram_rdata[7:0];
            2'b01:   byte_sel = i_ram_rdata[15:8];
            2'b10:   byte_sel = i_ram_rdata[23:16];
            default: byte_sel = i_ram_rdata[31:24];
        endcase
        half_sel = off_q[1] ? i_ram_rdata[31:16] : i_ram_rdata[15:0];

        load_val = i_ram_rdata;
        case (size_q)
            SZ_BYTE: load_val = unsigned_q ? {24'h000000, byte_sel}
                                           : {{24{byte_sel[7]}}, byte_sel};
            SZ_HALF: load_val = unsigned_q ? {16'h0000, half_sel}
                                           : {{16{half_sel[15]}}, half_sel};
            default: load_val = i_ram_rdata;
        endcase
    end

    // Lane replacement for sub-word stores.
    always_comb begin
        merge_val = i_ram_rdata;
        if (size_q == SZ_BYTE) begin
            case (off_q)
                2'b00:   merge_val[7:0]   = wdata_q[7:0];
                2'b01:   merge_val[15:8]  = wdata_q[7:0];
                2'b10:   merge_val[23:16] = wdata_q[7:0];
                default: merge_val[31:24] = wdata_q[7:0];
            endcase
        end else if (size_q == SZ_HALF) begin
            if (off_q[1]) begin
                merge_val[31:16] = wdata_q[15:0];
            end else begin
                merge_val[15:0] = wdata_q[15:0];
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            addr_q     <= '0;
            off_q      <= 2'b00;
            size_q     <= 2'b00;
            unsigned_q <= 1'b0;
            we_q       <= 1'b0;
            wdata_q    <= 32'h0;
            merge_q    <= 32'h0;
            rdata_q    <= 32'h0;
        end else begin
            if (state == ST_IDLE && i_req) begin
                addr_q     <= i_addr[RAM_AW+1:2];
                off_q      <= i_addr[1:0];
                size_q     <= i_size;
                unsigned_q <= i_unsigned;
                we_q       <= i_we;
                wdata_q    <= i_wdata;
            end
            if (state == ST_READ) begin
                if (we_q) begin
                    merge_q <= merge_val;
                end else begin
                    rdata_q <= load_val;
                end
            end
        end
    end

    assign ram_we_raw = (state == ST_ISSUE && we_q && size_q == SZ_WORD)
                     || (state == ST_WRITE);

    // Reset blocks the strobe combinationally so a mid-sequence reset never
    // corrupts the RAM.
    assign o_ram_we     = ram_we_raw && !i_rst;
    assign o_ram_wdata  = !o_ram_we ? 32'h0
                        : (state == ST_WRITE) ? merge_q : wdata_q;
    assign o_ram_addr   = addr_q;
    assign o_busy       = (state != ST_IDLE);
    assign o_done       = (state == ST_DONE) || (state == ST_ERR);
    assign o_misaligned = (state == ST_ERR);
    assign o_rdata      = rdata_q;

endmodule

// File: tb/tb_load_store_ctrl.sv
module tb_load_store_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] ram_rdata;
    logic        busy;
    logic        done;
    logic [31:0] rdata;
    logic        misaligned;
    logic [7:0]  ram_addr;
    logic        ram_we;
    logic [31:0] ram_wdata;

    int checks = 0;
    int errors = 0;

    load_store_ctrl #(.RAM_AW(8)) dut (
        .i_clk        (clk),
        .i_rst        (rst),
        .i_req        (req),
        .i_we         (we),
        .i_size       (size),
        .i_unsigned   (uns),
        .i_addr       (addr),
        .i_wdata      (wdata),
        .i_ram_rdata  (ram_rdata),
        .o_busy       (busy),
        .o_done       (done),
        .o_rdata      (rdata),
        .o_misaligned (misaligned),
        .o_ram_addr   (ram_addr),
        .o_ram_we     (ram_we),
        .o_ram_wdata  (ram_wdata)
    );

    always #5 clk = ~clk;

    // Synchronous-read RAM model with write logging.
    logic [31:0] mem [256];
    int          wr_count = 0;
    logic [31:0] last_wdata = 32'h0;
    logic [7:0]  last_waddr = 8'h0;

    always @(posedge clk) begin
        if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
            wr_count      <= wr_count + 1;
            last_wdata    <= ram_wdata;
            last_waddr    <= ram_addr;
        end
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        int          lat;
        logic        mis;
        logic [31:0] rdata;
        int          writes;
        logic [31:0] wdata;
        logic [7:0]  waddr;
    } exp_t;

    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic run_access(input string tag, input logic a_we, input logic [1:0] a_size,
                              input logic a_uns, input logic [31:0] a_addr,
                              input logic [31:0] a_wdata, input int exp_lat,
                              input logic exp_mis, input logic [31:0] exp_rdata,
                              input int exp_writes, input logic [31:0] exp_wdata,
                              input bit req_in_issue);
        exp_t e;
        int   n;
        int   w0;
        bit   wdata_leak;
        e.lat    = exp_lat;
        e.mis    = exp_mis;
        e.rdata  = exp_rdata;
        e.writes = exp_writes;
        e.wdata  = exp_wdata;
        e.waddr  = a_addr[9:2];
        exp_q.push_back(e);
        w0 = wr_count;
        wdata_leak = 1'b0;

        @(negedge clk);
        req   = 1'b1;
        we    = a_we;
        size  = a_size;
        uns   = a_uns;
        addr  = a_addr;
        wdata = a_wdata;
        @(posedge clk);
        n = 1;
        #1;
        if (!req_in_issue) req = 1'b0;
        while (!done && n < 20) begin
            if (!ram_we && ram_wdata !== 32'h0) wdata_leak = 1'b1;
            @(posedge clk);
            n++;
            #1;
            if (n == 2) req = 1'b0;
        end

        e = exp_q.pop_front();
        chk({tag, " latency"}, n, e.lat);
        chk({tag, " misaligned"}, {31'b0, misaligned}, {31'b0, e.mis});
        chk({tag, " rdata"}, rdata, e.rdata);
        @(posedge clk);
        #1;
        chk({tag, " writes"}, wr_count - w0, e.writes);
        if (e.writes > 0) begin
            chk({tag, " write data"}, last_wdata, e.wdata);
            chk({tag, " write addr"}, {24'h0, last_waddr}, {24'h0, e.waddr});
        end
        chk({tag, " wdata zero when idle"}, {31'b0, wdata_leak}, 32'h0);
        chk({tag, " done pulse ends"}, {31'b0, done}, 32'h0);
        chk({tag, " busy clear"}, {31'b0, busy}, 32'h0);
    endtask

    initial begin
        int w0;
        for (int i = 0; i < 256; i++) mem[i] = 32'h0;
        mem[4] = 32'h8899AABB;
        rst = 1'b1; req = 1'b0; we = 1'b0; size = 2'b00; uns = 1'b0;
        addr = 32'h0; wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", {31'b0, busy}, 32'h0);
        chk("reset done", {31'b0, done}, 32'h0);
        chk("reset misaligned", {31'b0, misaligned}, 32'h0);
        chk("reset ram_we", {31'b0, ram_we}, 32'h0);
        chk("reset rdata", rdata, 32'h0);
        @(negedge clk);
        rst = 1'b0;

        // Sub-word loads
        run_access("LB 0x11",  1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 3, 1'b0, 32'hFFFFFFAA, 0, 32'h0, 1'b0);
        run_access("LBU 0x11", 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 3, 1'b0, 32'h000000AA, 0, 32'h0, 1'b0);
        run_access("LH 0x12",  1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 3, 1'b0, 32'hFFFF8899, 0, 32'h0, 1'b0);
        run_access("LHU 0x12", 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 3, 1'b0, 32'h00008899, 0, 32'h0, 1'b0);
        run_access("LH 0x10",  1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hFFFFAABB, 0, 32'h0, 1'b0);

        // Byte store read-modify-write
        run_access("SB 0x13", 1'b1, 2'b00, 1'b0, 32'h13, 32'h12345655, 4, 1'b0, 32'hFFFFAABB, 1, 32'h5599AABB, 1'b0);
        run_access("LW 0x10", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'h5599AABB, 0, 32'h0, 1'b0);

        // Misaligned and illegal requests
        run_access("SH 0x11 mis", 1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF, 1, 1'b1, 32'h5599AABB, 0, 32'h0, 1'b0);
        run_access("LW 0x12 mis", 1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 1, 1'b1, 32'h5599AABB, 0, 32'h0, 1'b0);
        run_access("size11 mis",  1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 1, 1'b1, 32'h5599AABB, 0, 32'h0, 1'b0);

        // Word store with a stray request during ISSUE
        run_access("SW 0x10", 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 2, 1'b0, 32'h5599AABB, 1, 32'hDEADBEEF, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        chk("SW stray req ignored", {31'b0, busy}, 32'h0);
        run_access("LW after SW", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hDEADBEEF, 0, 32'h0, 1'b0);
        run_access("LB 0x10",  1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'hFFFFFFEF, 0, 32'h0, 1'b0);
        run_access("LBU 0x13", 1'b0, 2'b00, 1'b1, 32'h13, 32'h0, 3, 1'b0, 32'h000000DE, 0, 32'h0, 1'b0);

        // Upper halfword store
        run_access("SH 0x12", 1'b1, 2'b01, 1'b0, 32'h12, 32'hABCD1234, 4, 1'b0, 32'h000000DE, 1, 32'h1234BEEF, 1'b0);
        run_access("LW after SH", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'h1234BEEF, 0, 32'h0, 1'b0);

        // Reset during the WRITE cycle of SB 0x10
        w0 = wr_count;
        @(negedge clk);
        req = 1'b1; we = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h10; wdata = 32'h00000077;
        @(posedge clk);
        #1;
        req = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst-in-write busy before", {31'b0, busy}, 32'h1);
        rst = 1'b1;
        #1;
        chk("rst-in-write ram_we gated", {31'b0, ram_we}, 32'h0);
        @(posedge clk);
        #1;
        chk("rst-in-write busy after", {31'b0, busy}, 32'h0);
        chk("rst-in-write done after", {31'b0, done}, 32'h0);
        chk("rst-in-write rdata cleared", rdata, 32'h0);
        chk("rst-in-write no write", wr_count - w0, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        run_access("LW after rst", 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 3, 1'b0, 32'h1234BEEF, 0, 32'h0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
